// File: rtl/seg14_scan_sched.sv
// 12-digit 14-segment scan scheduler with a dual-requester, round-robin write port.
// Optional BLANK cycle between digits is enabled by defining SEG14_BLANK_EN.
module seg14_scan_sched #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        a_valid,
  input  logic [3:0]  a_addr,
  input  logic [13:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [3:0]  b_addr,
  input  logic [13:0] b_data,
  output logic        b_ready,
  output logic [11:0] sel,
  output logic [13:0] segm,
  output logic        frame_done
);

  localparam int NDIG = 12;

  typedef enum logic {S_SHOW, S_BLANK} state_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [13:0] data;
  } wr_req_t;

  logic [13:0] r_buf [NDIG];
  logic        r_prio_b;

  state_t      r_state, w_state_n;
  logic        r_pend, w_pend_n;
  logic [3:0]  r_idx, w_idx_n;
  logic [7:0]  r_dcnt, w_dcnt_n;
  logic [11:0] r_sel, w_sel_n;
  logic [13:0] r_segm, w_segm_n;
  logic        r_fd, w_fd_n;

  logic        w_wr_en;
  wr_req_t     w_wr;
  logic [3:0]  w_nxt_idx;
  logic [3:0]  w_tgt_idx;
  logic [13:0] w_tgt_data;

  // Round-robin: r_prio_b set means B wins the next tie.
  assign a_ready = !rst && a_valid && (!b_valid || !r_prio_b);
  assign b_ready = !rst && b_valid && (!a_valid || r_prio_b);
  assign w_wr_en = a_ready || b_ready;
  assign w_wr    = a_ready ? '{addr: a_addr, data: a_data}
                           : '{addr: b_addr, data: b_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_b <= 1'b0;
      for (int k = 0; k < NDIG; k++) r_buf[k] <= '0;
    end else if (w_wr_en) begin
      r_prio_b <= a_ready;
      if (w_wr.addr < 4'(NDIG)) r_buf[w_wr.addr] <= w_wr.data;
    end
  end

  // Digit about to be entered, with a same-edge write bypassed in (write-first).
  assign w_nxt_idx  = (r_idx == 4'(NDIG - 1)) ? 4'd0 : r_idx + 4'd1;
  assign w_tgt_idx  = (r_pend || r_state == S_BLANK) ? r_idx : w_nxt_idx;
  assign w_tgt_data = (w_wr_en && w_wr.addr == w_tgt_idx) ? w_wr.data
                                                          : r_buf[w_tgt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SHOW;
      r_pend  <= 1'b1;
      r_idx   <= '0;
      r_dcnt  <= '0;
      r_sel   <= '0;
      r_segm  <= '0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_idx   <= w_idx_n;
      r_dcnt  <= w_dcnt_n;
      r_sel   <= w_sel_n;
      r_segm  <= w_segm_n;
      r_fd    <= w_fd_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend;
    w_idx_n   = r_idx;
    w_dcnt_n  = r_dcnt;
    w_sel_n   = r_sel;
    w_segm_n  = r_segm;
    w_fd_n    = 1'b0;
    if (!en) begin
      // Freeze index/counter; resume re-enters the same digit with a fresh dwell.
      w_sel_n  = '0;
      w_segm_n = '0;
      w_pend_n = 1'b1;
    end else if (r_pend || r_state == S_BLANK) begin
      w_state_n = S_SHOW;
      w_pend_n  = 1'b0;
      w_sel_n   = 12'(1) << w_tgt_idx;
      w_segm_n  = w_tgt_data;
      w_dcnt_n  = 8'd1;
    end else if (r_dcnt >= 8'(DWELL)) begin
      w_fd_n  = (r_idx == 4'(NDIG - 1));
      w_idx_n = w_nxt_idx;
`ifdef SEG14_BLANK_EN
      w_state_n = S_BLANK;
      w_sel_n   = '0;
      w_segm_n  = '0;
`else
      w_sel_n   = 12'(1) << w_tgt_idx;
      w_segm_n  = w_tgt_data;
      w_dcnt_n  = 8'd1;
`endif
    end else begin
      w_dcnt_n = r_dcnt + 8'd1;
    end
  end

  assign sel        = r_sel;
  assign segm       = r_segm;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seg14_scan_sched.sv
// Scoreboard bench for seg14_scan_sched: driver runs a phase-based reference model
// and queues expectations; an independent monitor pops and compares every cycle.
module tb_seg14_scan_sched;

  localparam int DW = 4;
`ifdef SEG14_BLANK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif
  localparam int P = DW + BL;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  a_addr = '0, b_addr = '0;
  logic [13:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic [11:0] sel;
  logic [13:0] segm;
  logic        frame_done;

  always #5 clk = ~clk;

  seg14_scan_sched #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .segm(segm), .frame_done(frame_done)
  );

  typedef struct { logic ar; logic br; } rdy_t;
  typedef struct { logic [11:0] sel; logic [13:0] segm; logic fd; } out_t;

  rdy_t qr[$];
  out_t qo[$];
  int checks = 0, failures = 0;

  // Reference model: buffer contents, grant history, and scan position as a phase in a period.
  logic [13:0] m_buf [12];
  int          m_idx = 0, m_phase = 0;
  bit          m_active = 0, m_last_a = 0;
  logic [13:0] m_snap = '0;

  task automatic model_step();
    rdy_t r;
    out_t o;
    int   g;
    g = 0;
    if (!rst) begin
      if (a_valid && b_valid) g = m_last_a ? 2 : 1;
      else if (a_valid)       g = 1;
      else if (b_valid)       g = 2;
    end
    r.ar = (g == 1);
    r.br = (g == 2);
    qr.push_back(r);
    o.sel = '0; o.segm = '0; o.fd = 1'b0;
    if (rst) begin
      for (int k = 0; k < 12; k++) m_buf[k] = '0;
      m_idx = 0; m_phase = 0; m_active = 0; m_last_a = 0; m_snap = '0;
    end else begin
      if (g == 1) begin
        if (int'(a_addr) < 12) m_buf[int'(a_addr)] = a_data;
        m_last_a = 1;
      end else if (g == 2) begin
        if (int'(b_addr) < 12) m_buf[int'(b_addr)] = b_data;
        m_last_a = 0;
      end
      if (!en) m_active = 0;
      else if (!m_active) begin
        m_active = 1; m_phase = 0; m_snap = m_buf[m_idx];
      end else begin
        m_phase++;
        if (m_phase == DW) begin
          o.fd  = (m_idx == 11);
          m_idx = (m_idx + 1) % 12;
        end
        if (m_phase == P) begin
          m_phase = 0;
          m_snap  = m_buf[m_idx];
        end
      end
      if (m_active && m_phase < DW) begin
        o.sel  = 12'(1) << m_idx;
        o.segm = m_snap;
      end
    end
    qo.push_back(o);
  endtask

  task automatic drive(input bit r, input bit e,
                       input bit av, input logic [3:0] aa, input logic [13:0] ad,
                       input bit bv, input logic [3:0] ba, input logic [13:0] bd);
    @(negedge clk);
    rst = r; en = e;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 1, 0, 4'd0, 14'd0, 0, 4'd0, 14'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  // Monitor: readies just before each edge, registered outputs just after.
  initial begin
    rdy_t r;
    out_t o;
    forever begin
      @(negedge clk); #3;
      if (qr.size() > 0) begin
        r = qr.pop_front();
        chk("a_ready", 32'(a_ready), 32'(r.ar));
        chk("b_ready", 32'(b_ready), 32'(r.br));
      end
      @(posedge clk); #1;
      if (qo.size() > 0) begin
        o = qo.pop_front();
        chk("sel", 32'(sel), 32'(o.sel));
        chk("segm", 32'(segm), 32'(o.segm));
        chk("frame_done", 32'(frame_done), 32'(o.fd));
      end
    end
  end

  initial begin
    bit e;
    repeat (3) drive(1, 1, 0, 4'd0, 14'd0, 0, 4'd0, 14'd0);
    idle(2 * 12 * P + 5);
    // Single digit write, then watch a full frame
    drive(0, 1, 1, 4'd3, 14'b11011011000000, 0, 4'd0, 14'd0);
    idle(12 * P + 4);
    // Both requesters valid back to back: alternating grants
    for (int k = 0; k < 8; k++)
      drive(0, 1, 1, 4'(k), 14'($urandom), 1, 4'((k + 4) % 12), 14'($urandom));
    idle(12 * P + 4);
    // Out-of-range address completes but leaves buffer untouched
    drive(0, 1, 0, 4'd0, 14'd0, 1, 4'd13, 14'h3fff);
    idle(12 * P + 4);
    // Reset mid-frame around digit 6, then en low for 5 cycles
    drive(1, 1, 0, 4'd0, 14'd0, 0, 4'd0, 14'd0);
    idle(6 * P + 2);
    drive(1, 1, 0, 4'd0, 14'd0, 0, 4'd0, 14'd0);
    idle(3);
    repeat (5) drive(0, 0, 0, 4'd0, 14'd0, 0, 4'd0, 14'd0);
    idle(12 * P + 4);
    // Randomized traffic with sporadic en drops and resets
    e = 1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 29) == 0) e = ~e;
      drive(($urandom_range(0, 249) == 0), e,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 14'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 14'($urandom));
    end
    idle(2);
    @(posedge clk); #3;
    chk("queue_drained", 32'(qo.size() + qr.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg14_scan_sched.md
SEG14_SCAN_SCHED -- requirements
Module: seg14_scan_sched

Interface
REQ-001 SHALL provide parameter DWELL, default 4, meaning clock cycles each digit is driven; legal range 1..255.
REQ-002 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port en  input  1  scan enable; low freezes the scan and blanks the outputs.
REQ-005 SHALL provide ports a_valid/a_addr/a_data/a_ready  in/in/in/out  1/4/14/1  requester A digit-write handshake.
REQ-006 SHALL provide ports b_valid/b_addr/b_data/b_ready  in/in/in/out  1/4/14/1  requester B digit-write handshake, same format as A.
REQ-007 SHALL provide port sel  output  12  registered one-hot digit select; bit i selects digit i.
REQ-008 SHALL provide port segm  output  14  registered 14-segment pattern for the selected digit.
REQ-009 SHALL provide port frame_done  output  1  registered one-cycle pulse at the end of digit 11.

Function
REQ-010 SHALL hold a 12 x 14-bit frame buffer, one entry per digit.
REQ-011 A write SHALL occur on an edge where x_valid and x_ready are both high; buf[x_addr] <= x_data.
REQ-012 x_ready SHALL be combinational; at most one of a_ready/b_ready high per cycle.
REQ-013 With one valid requester, that requester SHALL receive ready in the same cycle.
REQ-014 With both valid, grant SHALL go to the requester not granted last (round-robin); the last-grant pointer updates only on a completed write.
REQ-015 A write with addr >= 12 SHALL complete the handshake and leave the buffer unchanged.
REQ-016 The scan FSM SHALL have states SHOW and BLANK; index i is 0..11, dwell counter d.
REQ-017 On entry to SHOW for digit i: sel <= onehot(i), segm <= buf[i] (sampled at entry; later writes to buf[i] appear on the next visit).
REQ-018 SHOW SHALL last exactly DWELL cycles, then advance i (11 wraps to 0).
REQ-019 A write at the same edge as SHOW entry for the same address SHALL be shown as the new data (write-first).
REQ-020 frame_done SHALL pulse high for one cycle, the first cycle after digit 11's SHOW ends.
REQ-021 While en=0: sel=0, segm=0, i and d frozen; on en rising, SHOW re-enters digit i with a fresh dwell.
REQ-022 Writes SHALL be accepted regardless of en.

Reset
REQ-023 On rst=1 at a clock edge: sel=0, segm=0, frame_done=0, i=0, d=0, state SHOW-pending, round-robin pointer favours A, all buffer entries 14'b0.
REQ-024 Reset mid-frame SHALL abort the current digit; the first cycle after rst falls with en=1 enters SHOW for digit 0.
REQ-025 ready outputs SHALL be 0 while rst=1; no write completes during reset.

Configuration
REQ-026 Macro SEG14_BLANK_EN defined: after each SHOW, one BLANK cycle with sel=0, segm=0 before the next digit (frame = 12*(DWELL+1) cycles); frame_done asserts in the BLANK cycle following digit 11.
REQ-027 Macro SEG14_BLANK_EN undefined: no BLANK state; digits are back-to-back (frame = 12*DWELL cycles).

Verification
REQ-028 Reset, en=1, DWELL=4, blank off -> sel=12'h001 for 4 cycles, then 12'h002; frame_done every 48 cycles.
REQ-029 A writes addr 3 data 14'b11011011000000 -> when sel=12'h008, segm=14'b11011011000000; all other digits show 0.
REQ-030 A and B valid continuously, first cycle -> A granted, then B, then A alternately; both buffers updated in that order.
REQ-031 B writes addr 13 -> b_ready=1, buffer contents unchanged across a full frame.
REQ-032 SEG14_BLANK_EN defined, DWELL=2 -> sel sequence 001,001,000,002,002,000,...; frame 36 cycles.
REQ-033 rst pulsed while sel=12'h040, then en toggled low 5 cycles -> sel=0, scan restarts at 12'h001, and frozen digit resumes with full DWELL.
